// File: rtl/pipe_stage_skid.sv
// Reusable pipeline stage register with a valid/ready handshake on both sides.
// Optional macro PIPE_SKID_EN adds a second (skid) entry so that in_ready
// does not depend combinationally on out_ready. Without the macro the stage
// holds a single entry.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall               freeze: no push, no pop, all registers hold
//   flush               kill all held entries (control forced to NOP_CTRL)
//   in_valid/in_ready   upstream handshake; in_ctrl/in_data upstream fields
//   out_valid/out_ready downstream handshake; out_ctrl/out_data main entry
//   occupancy           number of held entries (0..2)
//   bp_cnt              saturating count of cycles with out_valid and no pop
module pipe_stage_skid #(
   parameter int unsigned       CTRL_W   = 16,
   parameter int unsigned       DATA_W   = 96,
   parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}},
   parameter int unsigned       CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bp_cnt
);

   // State code equals the number of held entries.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CNT_W-1:0]  bp_q, bp_d;
`ifdef PIPE_SKID_EN
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              skid_v;
`endif
   logic              main_v;
   logic              push;
   logic              pop;

   assign main_v = (state_q != EMPTY);

`ifdef PIPE_SKID_EN
   // Ready depends only on the skid flag and stall, never on out_ready.
   assign skid_v   = (state_q == TWO);
   assign in_ready = ~skid_v & ~stall;
`else
   // Single entry: accept when empty or when the held entry leaves this cycle.
   assign in_ready = ~stall & (~main_v | out_ready);
`endif

   assign push = in_valid & in_ready;
   assign pop  = main_v & out_ready & ~stall;

   assign out_valid = main_v;
   assign out_ctrl  = main_ctrl_q;
   assign out_data  = main_data_q;
   assign occupancy = 2'(state_q);
   assign bp_cnt    = bp_q;

   // State register and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_ctrl_q <= NOP_CTRL;
         main_data_q <= '0;
         bp_q        <= '0;
`ifdef PIPE_SKID_EN
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         bp_q        <= bp_d;
`ifdef PIPE_SKID_EN
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
`endif
      end
   end

   // Next-state and next-register logic; flush overrides stall and push.
   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      bp_d        = bp_q;
`ifdef PIPE_SKID_EN
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
`endif

      if (main_v && !pop && !flush && (bp_q != {CNT_W{1'b1}}))
         bp_d = bp_q + CNT_W'(1);

      if (flush) begin
         state_d     = EMPTY;
         main_ctrl_d = NOP_CTRL;
`ifdef PIPE_SKID_EN
         skid_ctrl_d = NOP_CTRL;
`endif
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_d     = ONE;
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end
            end
            ONE: begin
               if (push && pop) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
`ifdef PIPE_SKID_EN
               end else if (push) begin
                  state_d     = TWO;
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
`endif
               end else if (pop) begin
                  state_d     = EMPTY;
                  main_ctrl_d = NOP_CTRL;
               end
            end
`ifdef PIPE_SKID_EN
            TWO: begin
               // Skid drains into main so arrival order is preserved.
               if (pop) begin
                  state_d     = ONE;
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
               end
            end
`endif
            default: begin
               state_d     = EMPTY;
               main_ctrl_d = NOP_CTRL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed table, corner-case sequences and a
// randomized run against a queue-based reference model. Works with and
// without PIPE_SKID_EN.
module tb_pipe_stage_skid;

   localparam logic [15:0] NOP = 16'hF00F;
`ifdef PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic        clk, rst, stall, flush, in_valid, out_ready;
   logic [15:0] in_ctrl;
   logic [31:0] in_data;
   logic        in_ready, out_valid;
   logic [15:0] out_ctrl;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
   logic [15:0] bp_cnt;
   logic        in_ready2, out_valid2;
   logic [15:0] out_ctrl2;
   logic [31:0] out_data2;
   logic [1:0]  occupancy2;
   logic [3:0]  bp_cnt2;

   pipe_stage_skid #(.CTRL_W(16), .DATA_W(32), .NOP_CTRL(NOP), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_data(out_data), .occupancy(occupancy), .bp_cnt(bp_cnt));

   pipe_stage_skid #(.CTRL_W(16), .DATA_W(32), .NOP_CTRL(NOP), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready2), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2),
      .out_data(out_data2), .occupancy(occupancy2), .bp_cnt(bp_cnt2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [15:0] c;
      logic [31:0] d;
   } ent_t;

   typedef struct {
      logic        st, fl, iv, ordy;
      logic [15:0] c;
      logic [31:0] d;
      logic        e_ir, e_ov;
      logic [15:0] e_ctrl;
      logic [1:0]  e_occ;
      int          e_bp;
   } vec_t;

   int total = 0;
   int bad   = 0;

   // Reference model: FIFO of held entries plus counters.
   ent_t        mq[$];
   logic [31:0] mheld;
   int          mbp, mbp4;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      if (SKID) return !stall && (mq.size() < 2);
      return !stall && (mq.size() == 0 || out_ready);
   endfunction

   function automatic logic [15:0] m_ctrl();
      if (mq.size() > 0) return mq[0].c;
      return NOP;
   endfunction

   task automatic m_reset();
      mq.delete();
      mheld = '0;
      mbp   = 0;
      mbp4  = 0;
   endtask

   task automatic check_model();
      chk("in_ready",   64'(in_ready),   64'(m_ready()));
      chk("out_valid",  64'(out_valid),  64'(mq.size() > 0));
      chk("out_ctrl",   64'(out_ctrl),   64'(m_ctrl()));
      chk("out_data",   64'(out_data),   64'(mheld));
      chk("occupancy",  64'(occupancy),  64'(mq.size()));
      chk("bp_cnt",     64'(bp_cnt),     64'(mbp));
      chk("out_ctrl4",  64'(out_ctrl2),  64'(m_ctrl()));
      chk("occupancy4", 64'(occupancy2), 64'(mq.size()));
      chk("in_ready4",  64'(in_ready2),  64'(m_ready()));
      chk("out_valid4", 64'(out_valid2), 64'(mq.size() > 0));
      chk("out_data4",  64'(out_data2),  64'(mheld));
      chk("bp_cnt4",    64'(bp_cnt2),    64'(mbp4));
   endtask

   // Drive inputs at the falling edge, then check against the model.
   task automatic apply(input logic st, input logic fl, input logic iv, input logic ordy,
                        input logic [15:0] c, input logic [31:0] d);
      stall = st; flush = fl; in_valid = iv; out_ready = ordy;
      in_ctrl = c; in_data = d;
      #1;
      check_model();
   endtask

   // Advance model and DUT by one rising edge.
   task automatic adv();
      bit   rdy, psh, pp;
      ent_t e;
      rdy = m_ready();
      psh = in_valid && rdy;
      pp  = (mq.size() > 0) && out_ready && !stall;
      if (mq.size() > 0 && !pp && !flush) begin
         if (mbp < 65535) mbp++;
         if (mbp4 < 15) mbp4++;
      end
      if (flush) mq.delete();
      else begin
         if (pp) void'(mq.pop_front());
         if (psh) begin
            e.c = in_ctrl;
            e.d = in_data;
            mq.push_back(e);
         end
      end
      if (mq.size() > 0) mheld = mq[0].d;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic vec_t mk(input logic st, input logic fl, input logic iv, input logic ordy,
                               input logic [15:0] c, input logic e_ir, input logic e_ov,
                               input logic [15:0] e_ctrl, input logic [1:0] e_occ, input int e_bp);
      vec_t v;
      v.st = st; v.fl = fl; v.iv = iv; v.ordy = ordy;
      v.c = c; v.d = {16'h5A5A, c};
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_ctrl = e_ctrl; v.e_occ = e_occ; v.e_bp = e_bp;
      return v;
   endfunction

   vec_t tbl[10];

   initial begin
      // Expected values describe the stage just before the edge of each row.
      tbl[0] = mk(0, 0, 1, 0, 16'h00A1, 1,    0,    NOP,                 2'd0,              0);
      tbl[1] = mk(0, 0, 1, 0, 16'h00A2, SKID, 1,    16'h00A1,            2'd1,              0);
      tbl[2] = mk(0, 0, 1, 0, 16'h00A3, 0,    1,    16'h00A1,            SKID ? 2'd2 : 2'd1, 1);
      tbl[3] = mk(0, 0, 0, 1, 16'h0000, !SKID, 1,   16'h00A1,            SKID ? 2'd2 : 2'd1, 2);
      tbl[4] = mk(0, 0, 0, 1, 16'h0000, 1,    SKID, SKID ? 16'h00A2 : NOP, SKID ? 2'd1 : 2'd0, 2);
      tbl[5] = mk(0, 0, 1, 1, 16'h0033, 1,    0,    NOP,                 2'd0,              2);
      tbl[6] = mk(1, 0, 1, 1, 16'h0044, 0,    1,    16'h0033,            2'd1,              2);
      tbl[7] = mk(1, 0, 1, 1, 16'h0044, 0,    1,    16'h0033,            2'd1,              3);
      tbl[8] = mk(0, 1, 1, 1, 16'h0055, 1,    1,    16'h0033,            2'd1,              4);
      tbl[9] = mk(0, 0, 0, 0, 16'h0000, 1,    0,    NOP,                 2'd0,              4);

      rst = 1'b1; stall = 0; flush = 0; in_valid = 0; out_ready = 0;
      in_ctrl = '0; in_data = '0;
      m_reset();
      #12 rst = 1'b0;
      @(negedge clk);

      // Reset state.
      apply(0, 0, 0, 0, 16'h0, 32'h0);
      adv();

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         apply(tbl[i].st, tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].c, tbl[i].d);
         chk($sformatf("tbl%0d_in_ready", i),  64'(in_ready),  64'(tbl[i].e_ir));
         chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_out_ctrl", i),  64'(out_ctrl),  64'(tbl[i].e_ctrl));
         chk($sformatf("tbl%0d_occupancy", i), 64'(occupancy), 64'(tbl[i].e_occ));
         chk($sformatf("tbl%0d_bp_cnt", i),    64'(bp_cnt),    64'(tbl[i].e_bp));
         adv();
      end

      // Streaming: one-cycle latency, occupancy stays at 1, no backpressure.
      begin
         int b0;
         b0 = mbp;
         for (int i = 1; i <= 16; i++) begin
            apply(0, 0, 1, 1, 16'(i), 32'(i * 3));
            if (i > 1) chk("stream_ctrl", 64'(out_ctrl), 64'(i - 1));
            adv();
         end
         apply(0, 0, 0, 1, 16'h0, 32'h0);
         chk("stream_last", 64'(out_ctrl), 64'd16);
         chk("stream_bp", 64'(bp_cnt), 64'(b0));
         adv();
      end

      // Stall holds a single entry for five cycles, then it pops.
      begin
         int b0;
         apply(0, 0, 1, 1, 16'h0033, 32'h3333_0033);
         adv();
         b0 = mbp;
         for (int i = 0; i < 5; i++) begin
            apply(1, 0, 1, 1, 16'h0044, 32'h4444_0044);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_ctrl", 64'(out_ctrl), 64'h33);
            adv();
         end
         apply(0, 0, 0, 1, 16'h0, 32'h0);
         chk("stall_bp", 64'(bp_cnt), 64'(b0 + 5));
         chk("stall_release", 64'(out_ctrl), 64'h33);
         adv();
         apply(0, 0, 0, 0, 16'h0, 32'h0);
         chk("stall_drained", 64'(out_valid), 64'd0);
         adv();
      end

      // Flush with a concurrent push: the pushed entry is dropped, data kept.
      apply(0, 0, 1, 0, 16'h00A5, 32'h1111_00A5);
      adv();
      apply(0, 0, 1, 0, 16'h00A6, 32'h2222_00A6);
      adv();
      apply(0, 1, 1, 0, 16'h0055, 32'hDEAD_0055);
      chk("flush_pre_ctrl", 64'(out_ctrl), 64'hA5);
      adv();
      apply(0, 0, 0, 0, 16'h0, 32'h0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_ctrl", 64'(out_ctrl), 64'(NOP));
      chk("flush_data", 64'(out_data), 64'h1111_00A5);
      adv();

      // Asynchronous reset in the middle of a cycle with entries held.
      apply(0, 0, 1, 0, 16'h00B1, 32'h0000_00B1);
      adv();
      apply(0, 0, 1, 0, 16'h00B2, 32'h0000_00B2);
      adv();
      apply(0, 0, 0, 0, 16'h0, 32'h0);
      chk("pre_rst_occ", 64'(occupancy), SKID ? 64'd2 : 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_ctrl", 64'(out_ctrl), 64'(NOP));
      chk("arst_occ", 64'(occupancy), 64'd0);
      chk("arst_bp", 64'(bp_cnt), 64'd0);
      chk("arst_bp4", 64'(bp_cnt2), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      apply(0, 0, 0, 0, 16'h0, 32'h0);
      chk("post_rst_ready", 64'(in_ready), 64'd1);
      adv();

      // Saturation: one entry blocked for 20 cycles.
      apply(0, 0, 1, 0, 16'h00C1, 32'h0000_00C1);
      adv();
      for (int i = 0; i < 20; i++) begin
         apply(0, 0, 0, 0, 16'h0, 32'h0);
         adv();
      end
      apply(0, 0, 0, 0, 16'h0, 32'h0);
      chk("sat_bp4", 64'(bp_cnt2), 64'd15);
      chk("sat_bp16", 64'(bp_cnt), 64'd20);
      if (!SKID) begin
         chk("comb_ready_low", 64'(in_ready), 64'd0);
         apply(0, 0, 0, 1, 16'h0, 32'h0);
         chk("comb_ready_high", 64'(in_ready), 64'd1);
      end
      adv();

      // Randomized run against the model.
      for (int i = 0; i < 3000; i++) begin
         apply(($urandom % 8) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
               ($urandom % 2) == 0, 16'($urandom), 32'($urandom));
         adv();
      end
      apply(0, 0, 0, 0, 16'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Generic parametrised pipeline stage register that replaces the hand-written per-stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB) with one reusable block. It has separate control and payload fields, a valid/ready handshake on both sides, and a two-entry skid buffer so that in_ready is a pure register output. It also supports stage-wide stall and flush (bubble insertion) and a saturating backpressure counter for performance debug.

Parameters:
CTRL_W, 16, width of control field (ALU/RAM/WB/jump op bits); forced to NOP_CTRL on flush.
DATA_W, 96, width of payload field (operands, PC, immediates, reg addresses); never cleared by flush.
NOP_CTRL, {CTRL_W{1'b0}}, control value that encodes a bubble.
CNT_W, 16, width of the backpressure counter.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  freeze stage: blocks both push and pop while high
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream has an entry
in_ready  out  1  stage can accept (registered when PIPE_SKID_EN defined)
in_ctrl  in  CTRL_W  upstream control field
in_data  in  DATA_W  upstream payload
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  main entry control (NOP_CTRL when out_valid=0)
out_data  out  DATA_W  main entry payload
occupancy  out  2  entries held (0..2)
bp_cnt  out  CNT_W  cycles with out_valid=1 and no pop, saturating

Behaviour:
- Reset (async, rst=1): main_v=skid_v=0; out_ctrl=NOP_CTRL; out_data=0; skid regs=0; occupancy=0; bp_cnt=0; in_ready=1 once rst and stall are low.
- push = in_valid & in_ready; pop = out_valid & out_ready & ~stall.
- in_ready = ~skid_v & ~stall. skid_v is a flop, so in_ready has no combinational path from out_ready.
- out_valid = main_v; out_ctrl/out_data come straight from main regs, zero added latency; in->out latency is 1 cycle.
- States: EMPTY (main_v=0), ONE (main_v=1, skid_v=0), TWO (both 1). skid_v=1 implies main_v=1.
- EMPTY: push -> ONE, main<=in.
- ONE: push&~pop -> TWO, skid<=in. push&pop -> ONE, main<=in. pop&~push -> EMPTY, out_ctrl<=NOP_CTRL. Otherwise hold.
- TWO: in_ready=0, so no push. pop -> ONE, main<=skid. Otherwise hold.
- stall=1: no push, no pop, all regs hold, regardless of in_valid/out_ready.
- flush=1 (highest priority after rst, overrides stall and any push that cycle): next state EMPTY. main_v=skid_v=0; out_ctrl and skid ctrl <= NOP_CTRL; data regs keep their values. A push offered during flush is dropped; upstream sees in_ready per the pre-flush state and must itself be flushed.
- occupancy = main_v + skid_v.
- bp_cnt increments when out_valid & ~pop & ~flush; saturates at all-ones; only rst clears it.
- Order preserved: entries leave in arrival order; skid never bypasses main.

Optional Feature:
PIPE_SKID_EN.
- Defined: two-entry skid as above, with registered in_ready.
- Undefined: skid regs removed, single entry. in_ready = ~stall & (~main_v | out_ready). This is a combinational path from out_ready, so full throughput needs no skid. TWO is unreachable and occupancy is at most 1. Flush, stall, bp_cnt and reset behave identically.

Test Plan:
- Reset mid-stream: hold TWO state, assert rst asynchronously mid-cycle -> out_valid=0, out_ctrl=NOP_CTRL, occupancy=0, bp_cnt=0 immediately, without waiting for a clock edge.
- Streaming: in_valid=1, out_ready=1, push ctrl 0x0001..0x0010 over 16 cycles -> out_ctrl matches 1 cycle later, occupancy stays 1, bp_cnt=0.
- Backpressure: out_ready=0, push 0xA1, then 0xA2 -> occupancy=2, in_ready=0. Next, out_ready=1 -> pops in order 0xA1, 0xA2 on consecutive cycles; bp_cnt=count of blocked cycles.
- Flush vs push: state TWO, flush=1 with in_valid=1 and ctrl 0x55 -> next cycle out_valid=0, out_ctrl=NOP_CTRL, 0x55 never appears, out_data unchanged.
- Stall: state ONE with ctrl 0x33, stall=1 for 5 cycles with out_ready=1 and in_valid=1 -> no pop or push, in_ready=0, bp_cnt +5. Then release stall -> 0x33 pops.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles -> bp_cnt stops at 15. Without PIPE_SKID_EN, the same bench yields occupancy at most 1, and in_ready follows out_ready in the same cycle.
